// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DBITS register array, one write port, async read port
module fifo_mem #(
  parameter int DBITS = 8,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);
  localparam int DEPTH = 1 << ABITS;

  logic [DBITS-1:0] mem_q [DEPTH];

  // Storage: cleared on reset so an empty FIFO shows zero on the read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-word-fall-through FIFO
module fifo #(
  parameter int DBITS = 8,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] CNT_FULL = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] CNT_ONE  = (ABITS+1)'(1);

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   count_q, count_d;
  logic             push, pop;

  // A push into a full FIFO is only allowed when a pop frees a slot in the same cycle
  always_comb begin
    push     = wr && (!full || rd);
    pop      = rd && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Status flags straight from the registered count, no look-ahead
  always_comb begin
    full         = (count_q == CNT_FULL);
    empty        = (count_q == '0);
    almost_full  = (count_q >= CNT_FULL - CNT_ONE);
    almost_empty = (count_q <= CNT_ONE);
  end

  fifo_mem #(
    .DBITS (DBITS),
    .ABITS (ABITS)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );
endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - directed self-checking bench for fifo
module tb_fifo;
  localparam int DBITS = 26;
  localparam int ABITS = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [DBITS-1:0] din = '0;
  logic [DBITS-1:0] dout;
  logic             full, empty, almost_full, almost_empty;

  int errors = 0;
  int checks = 0;
  logic [DBITS-1:0] q [$];

  fifo #(.DBITS(DBITS), .ABITS(ABITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    int n;
    n = q.size();
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - 1));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
    if (n > 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the reference queue, sample 1 ns after the edge
  task automatic cycle(input logic w, input logic r, input logic [DBITS-1:0] d, input string tag);
    bit push_ok, pop_ok;
    wr = w; rd = r; din = d;
    push_ok = w && (q.size() < DEPTH || r);
    pop_ok  = r && (q.size() > 0);
    if (pop_ok)  void'(q.pop_front());
    if (push_ok) q.push_back(d);
    @(posedge clk);
    #1;
    chk_flags(tag);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.empty", 32'(empty), 1);
    chk("rst.almost_empty", 32'(almost_empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.almost_full", 32'(almost_full), 0);
    chk("rst.dout", 32'(dout), 0);

    // Pop while empty has no effect
    cycle(1'b0, 1'b1, '0, "rd_empty");
    chk("rd_empty.dout", 32'(dout), 0);

    // Fill with 0,8,...,120
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DBITS'(i * 8), "fill");
      if (i == 14) begin
        chk("fill15.almost_full", 32'(almost_full), 1);
        chk("fill15.full", 32'(full), 0);
      end
    end
    chk("fill16.full", 32'(full), 1);
    cycle(1'b1, 1'b0, DBITS'(999), "drop17");
    chk("drop17.dout", 32'(dout), 0);

    // Drain, expecting arithmetic order
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.dout", 32'(dout), 32'(i * 8));
      cycle(1'b0, 1'b1, '0, "drain");
    end
    chk("drain.empty", 32'(empty), 1);
    chk("drain.slot0_not_overwritten", 32'(dout), 0);

    // First-word fall-through
    cycle(1'b1, 1'b0, DBITS'('h155), "fwft_push");
    chk("fwft.dout", 32'(dout), 'h155);
    chk("fwft.empty", 32'(empty), 0);
    cycle(1'b0, 1'b1, '0, "fwft_pop");
    chk("fwft.empty_after", 32'(empty), 1);

    // Simultaneous push+pop while full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DBITS'(100 + i), "fill2");
    chk("full_wr_rd.head_before", 32'(dout), 100);
    cycle(1'b1, 1'b1, DBITS'(7), "full_wr_rd");
    chk("full_wr_rd.full", 32'(full), 1);
    chk("full_wr_rd.head_after", 32'(dout), 101);
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk("drain2.dout", 32'(dout), 32'(101 + i));
      cycle(1'b0, 1'b1, '0, "drain2");
    end
    chk("drain2.tail", 32'(dout), 7);
    cycle(1'b0, 1'b1, '0, "drain2_last");
    chk("drain2.empty", 32'(empty), 1);

    // Simultaneous push+pop while empty
    cycle(1'b1, 1'b1, DBITS'(55), "empty_wr_rd");
    chk("empty_wr_rd.empty", 32'(empty), 0);
    chk("empty_wr_rd.almost_empty", 32'(almost_empty), 1);
    chk("empty_wr_rd.dout", 32'(dout), 55);
    cycle(1'b0, 1'b1, '0, "empty_wr_rd_pop");

    // Wrap-around: backlog of 3, then alternating push/pop
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DBITS'(200 + i), "backlog");
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'b0, DBITS'(300 + i), "wrap_push");
      else            cycle(1'b0, 1'b1, '0, "wrap_pop");
    end

    // Async reset mid-operation with 5 entries stored
    wr = 1'b0; rd = 1'b0;
    while (q.size() > 5) cycle(1'b0, 1'b1, '0, "trim");
    while (q.size() < 5) cycle(1'b1, 1'b0, DBITS'(500 + q.size()), "top_up");
    chk("pre_reset.empty", 32'(empty), 0);
    wr = 1'b0; rd = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_rst.empty", 32'(empty), 1);
    chk("async_rst.full", 32'(full), 0);
    chk("async_rst.dout", 32'(dout), 0);
    q.delete();
    #1 reset = 1'b1;
    cycle(1'b1, 1'b0, DBITS'(42), "post_rst_push");
    chk("post_rst.dout", 32'(dout), 42);
    cycle(1'b0, 1'b0, '0, "idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-word-fall-through FIFO used as an address-tracking queue between the VGA read master and the SDRAM bus. The master pushes each issued read address and pops the oldest one when the bus returns read data. The head entry is always visible on `dout`, so the popped value is usable in the same cycle as `rd`.

## Interface
- `DBITS`, default 8: data width in bits. The VGA master instantiates it with 26.
- `ABITS`, default 4: address bits; depth is DEPTH = 2^ABITS, 16 entries by default.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `wr` input 1: push request; `din` is written when accepted.
- `rd` input 1: pop request; removes the head entry when accepted.
- `din` input DBITS: write data.
- `dout` output DBITS: head entry, combinational from storage (FWFT).
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count >= DEPTH-1.
- `almost_empty` output 1: count <= 1.

## Operation
- Circular buffer with write pointer, read pointer and count. Count width is ABITS+1.
- Push accepted when `wr` && (!full || rd).
  - Data is stored at the write pointer, and the pointer increments modulo DEPTH.
- Pop accepted when `rd` && !empty.
  - The read pointer increments modulo DEPTH.
- Count update per cycle: +1 for a push alone, -1 for a pop alone, unchanged when both or neither occur.
- Rejected requests are silently ignored. There is no error flag and no state change.
  - `wr` while full with no `rd`: dropped.
  - `rd` while empty: no effect.
- Simultaneous `wr` and `rd`:
  - When empty: the write is accepted and the pop is ignored, so count becomes 1.
  - When full: both are accepted, so count stays DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- `dout` = mem[rd_ptr] at all times.
  - It is valid when !empty.
  - When empty it shows stale memory contents, which are 0 after reset.
- Flags are decoded combinationally from the registered count.
- Pointers wrap from DEPTH-1 to 0 without a gap.

## Timing
- Reset (async assert, sync release):
  - Pointers and count are 0, and all memory words are 0.
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `dout`=0.
- Write-to-read latency is one cycle. A word pushed at edge N appears on `dout` after edge N if the FIFO was empty.
- A pop takes effect at the clock edge. The next entry appears on `dout` immediately after that edge.
- Flags change in the cycle following the edge that changed the count. There is no look-ahead.
- Reset asserted mid-operation clears all contents immediately. Pushes in flight are lost.

## Structure
- No shared package is needed. Flags are derived from DEPTH locally.
- Natural sub-module: `fifo_mem`, a DEPTH x DBITS register array with one write port and an asynchronous read port.
- The pointer, count and flag logic lives in the top level.

## Test plan
- Reset check: after reset release, expect `empty`=1, `almost_empty`=1, `full`=0, `dout`=0.
  - Assert `rd` while empty; count must stay 0.
- Fill and drain, DBITS=26:
  - Push 0, 8, 16, …, 120. After 15 pushes `almost_full`=1; after 16 pushes `full`=1.
  - A 17th push of 999 is dropped.
  - Pop 16 times; `dout` must read 0, 8, …, 120 in order, and then `empty`=1.
- FWFT: from empty, push 0x155 at edge N. `dout`=0x155 after edge N.
  - Assert `rd` in the next cycle with `dout` still 0x155; `empty`=1 afterwards.
- Simultaneous access:
  - When full, push 7 with `rd` together: count stays 16, the head advances, and 7 appears at the tail.
  - When empty, `wr`+`rd` together: count becomes 1.
- Wrap-around: 40 cycles of alternating push/pop with a 3-entry backlog.
  - Data order is preserved across the pointer wrap, and flags stay consistent with the count.
- Async reset mid-operation: with 5 entries stored, drop `reset` between clock edges.
  - `empty` asserts immediately.
  - After release, a push of 42 reads back 42.
